// File: rtl/regfile_dump_streamer_if.sv
// Byte-stream valid/ready bus carrying a register-file dump frame.
interface regfile_dump_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_streamer.sv
// Snapshots the 16 register-file values on start and streams them as a byte frame:
// header, 64 data bytes, XOR checksum (flagged with out_last).
module regfile_dump_streamer #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter bit         BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] register_32bits_0_value,
  input  logic [31:0] register_32bits_1_value,
  input  logic [31:0] register_32bits_2_value,
  input  logic [31:0] register_32bits_3_value,
  input  logic [31:0] register_32bits_4_value,
  input  logic [31:0] register_32bits_5_value,
  input  logic [31:0] register_32bits_6_value,
  input  logic [31:0] register_32bits_7_value,
  input  logic [31:0] register_32bits_8_value,
  input  logic [31:0] register_32bits_9_value,
  input  logic [31:0] register_32bits_10_value,
  input  logic [31:0] register_32bits_11_value,
  input  logic [31:0] register_32bits_12_value,
  input  logic [31:0] register_32bits_13_value,
  input  logic [31:0] register_32bits_14_value,
  input  logic [31:0] register_32bits_15_value,
  output logic        busy,
  output logic        done,
  regfile_dump_streamer_if.master stream
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

  state_t      state;
  logic [5:0]  idx;
  logic [5:0]  nxt_idx;
  logic [7:0]  csum;
  logic [31:0] live [16];
  logic [31:0] snap [16];
  logic        hs;

  assign live[0]  = register_32bits_0_value;
  assign live[1]  = register_32bits_1_value;
  assign live[2]  = register_32bits_2_value;
  assign live[3]  = register_32bits_3_value;
  assign live[4]  = register_32bits_4_value;
  assign live[5]  = register_32bits_5_value;
  assign live[6]  = register_32bits_6_value;
  assign live[7]  = register_32bits_7_value;
  assign live[8]  = register_32bits_8_value;
  assign live[9]  = register_32bits_9_value;
  assign live[10] = register_32bits_10_value;
  assign live[11] = register_32bits_11_value;
  assign live[12] = register_32bits_12_value;
  assign live[13] = register_32bits_13_value;
  assign live[14] = register_32bits_14_value;
  assign live[15] = register_32bits_15_value;

  assign hs      = stream.out_valid && stream.out_ready;
  assign nxt_idx = idx + 6'd1;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [1:0] sel;
    sel = BIG_ENDIAN ? (2'd3 - lane) : lane;
    return word[8*sel +: 8];
  endfunction

  // Snapshot is pure data: no reset, captured only when a dump is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      snap <= live;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      csum             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      stream.out_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state            <= HDR;
            idx              <= '0;
            csum             <= '0;
            busy             <= 1'b1;
            stream.out_valid <= 1'b1;
            stream.out_data  <= HEADER;
          end
        end
        HDR: begin
          if (hs) begin
            state           <= DATA;
            stream.out_data <= lane_byte(snap[0], 2'd0);
          end
        end
        DATA: begin
          if (hs) begin
            csum <= csum ^ stream.out_data;
            idx  <= nxt_idx;
            // The last data byte folds straight into the checksum being presented.
            if (idx == 6'd63) begin
              state           <= CSUM;
              stream.out_data <= csum ^ stream.out_data;
              stream.out_last <= 1'b1;
            end else begin
              stream.out_data <= lane_byte(snap[nxt_idx[5:2]], nxt_idx[1:0]);
            end
          end
        end
        CSUM: begin
          if (hs) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b1;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Bench: little- and big-endian instances share stimulus; a frame-level queue model checks both every cycle.
module tb_regfile_dump_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [31:0] regs [16];
  logic        busy_le, done_le, busy_be, done_be;

  int vectors = 0;
  int fails   = 0;

  regfile_dump_streamer_if bus_le ();
  regfile_dump_streamer_if bus_be ();
  assign bus_le.out_ready = ready;
  assign bus_be.out_ready = ready;

  always #5 clk = ~clk;

  regfile_dump_streamer #(.HEADER(8'hA5), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .start(start),
    .register_32bits_0_value(regs[0]),   .register_32bits_1_value(regs[1]),
    .register_32bits_2_value(regs[2]),   .register_32bits_3_value(regs[3]),
    .register_32bits_4_value(regs[4]),   .register_32bits_5_value(regs[5]),
    .register_32bits_6_value(regs[6]),   .register_32bits_7_value(regs[7]),
    .register_32bits_8_value(regs[8]),   .register_32bits_9_value(regs[9]),
    .register_32bits_10_value(regs[10]), .register_32bits_11_value(regs[11]),
    .register_32bits_12_value(regs[12]), .register_32bits_13_value(regs[13]),
    .register_32bits_14_value(regs[14]), .register_32bits_15_value(regs[15]),
    .busy(busy_le), .done(done_le), .stream(bus_le)
  );

  regfile_dump_streamer #(.HEADER(8'hA5), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .start(start),
    .register_32bits_0_value(regs[0]),   .register_32bits_1_value(regs[1]),
    .register_32bits_2_value(regs[2]),   .register_32bits_3_value(regs[3]),
    .register_32bits_4_value(regs[4]),   .register_32bits_5_value(regs[5]),
    .register_32bits_6_value(regs[6]),   .register_32bits_7_value(regs[7]),
    .register_32bits_8_value(regs[8]),   .register_32bits_9_value(regs[9]),
    .register_32bits_10_value(regs[10]), .register_32bits_11_value(regs[11]),
    .register_32bits_12_value(regs[12]), .register_32bits_13_value(regs[13]),
    .register_32bits_14_value(regs[14]), .register_32bits_15_value(regs[15]),
    .busy(busy_be), .done(done_be), .stream(bus_be)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: bytes still owed by each instance, in order.
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  bit         active   = 1'b0;
  bit         done_exp = 1'b0;
  bit         chk_en   = 1'b0;
  logic [7:0] c0, c1, b0, b1;

  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      active   = 1'b0;
      done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (active) begin
        if (ready) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
          if (q0.size() == 0) begin
            active   = 1'b0;
            done_exp = 1'b1;
          end
        end
      end else if (start) begin
        q0.push_back(8'hA5);
        q1.push_back(8'hA5);
        c0 = 8'h00;
        c1 = 8'h00;
        for (int r = 0; r < 16; r++) begin
          for (int b = 0; b < 4; b++) begin
            b0 = regs[r][8*b +: 8];
            b1 = regs[r][8*(3-b) +: 8];
            q0.push_back(b0);
            q1.push_back(b1);
            c0 = c0 ^ b0;
            c1 = c1 ^ b1;
          end
        end
        q0.push_back(c0);
        q1.push_back(c1);
        active = 1'b1;
      end
    end
  end

  // Per-cycle comparison plus capture of accepted bytes for the literal frame checks.
  logic [8:0] cap0 [$];
  logic [8:0] cap1 [$];
  int done_cnt = 0;
  int vld_cnt  = 0;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("le_valid", bus_le.out_valid, active);
      chk("le_busy", busy_le, active);
      chk("le_done", done_le, done_exp);
      chk("be_valid", bus_be.out_valid, active);
      chk("be_busy", busy_be, active);
      chk("be_done", done_be, done_exp);
      if (active) begin
        chk("le_data", bus_le.out_data, q0[0]);
        chk("le_last", bus_le.out_last, q0.size() == 1);
        chk("be_data", bus_be.out_data, q1[0]);
        chk("be_last", bus_be.out_last, q1.size() == 1);
      end
      if (bus_le.out_valid) vld_cnt++;
      if (done_le) done_cnt++;
      if (bus_le.out_valid && ready) cap0.push_back({bus_le.out_last, bus_le.out_data});
      if (bus_be.out_valid && ready) cap1.push_back({bus_be.out_last, bus_be.out_data});
    end
  end

  bit rand_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
    done_cnt = 0;
    vld_cnt  = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 600 && done_cnt == 0; i++) tick();
    chk({name, "_done_seen"}, done_cnt != 0, 1'b1);
    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 400 && cap0.size() < n; i++) tick();
  endtask

  // Hand-computed frame for reg1 = 12345678, all other registers zero.
  task automatic check_frame(input string name);
    logic [8:0] e0, e1;
    int bad0, bad1;
    logic [7:0] le_b [4];
    logic [7:0] be_b [4];
    le_b = '{8'h78, 8'h56, 8'h34, 8'h12};
    be_b = '{8'h12, 8'h34, 8'h56, 8'h78};
    bad0 = 0;
    bad1 = 0;
    chk({name, "_le_len"}, cap0.size(), 66);
    chk({name, "_be_len"}, cap1.size(), 66);
    if (cap0.size() == 66 && cap1.size() == 66) begin
      for (int i = 0; i < 66; i++) begin
        if (i == 0)               begin e0 = 9'h0A5;           e1 = 9'h0A5; end
        else if (i >= 5 && i < 9) begin e0 = {1'b0, le_b[i-5]}; e1 = {1'b0, be_b[i-5]}; end
        else if (i == 65)         begin e0 = 9'h108;           e1 = 9'h108; end
        else                      begin e0 = 9'h000;           e1 = 9'h000; end
        if (cap0[i] !== e0) bad0++;
        if (cap1[i] !== e1) bad1++;
      end
      chk({name, "_le_bytes_bad"}, bad0, 0);
      chk({name, "_be_bytes_bad"}, bad1, 0);
      chk({name, "_le_reg1_lsb"}, cap0[5], 9'h078);
      chk({name, "_be_reg1_msb"}, cap1[5], 9'h012);
      chk({name, "_csum"}, cap0[65], 9'h108);
    end
    chk({name, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    for (int r = 0; r < 16; r++) regs[r] = 32'h0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus_le.out_valid, 1'b0);
    chk("rst_busy", busy_le, 1'b0);
    chk("rst_done", done_le, 1'b0);
    chk("rst_data", bus_le.out_data, 8'h00);
    chk("rst_last", bus_be.out_last, 1'b0);
    tick();

    // 1/2: basic frame, both byte orders, ready tied high
    regs[1] = 32'h12345678;
    clear_caps();
    pulse_start();
    wait_done("t1");
    check_frame("t1");
    chk("t1_valid_cycles", vld_cnt, 66);

    // 3: random backpressure
    clear_caps();
    rand_ready = 1'b1;
    pulse_start();
    wait_done("t3");
    check_frame("t3");

    // 4: inputs change right after the snapshot edge
    clear_caps();
    pulse_start();
    regs[1] = 32'hFFFFFFFF;
    wait_done("t4");
    check_frame("t4");
    regs[1] = 32'h12345678;

    // 5: start while busy is ignored
    clear_caps();
    pulse_start();
    wait_bytes(10);
    pulse_start();
    wait_done("t5");
    check_frame("t5");

    // 6: reset mid-frame, then a fresh frame
    clear_caps();
    pulse_start();
    wait_bytes(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", bus_le.out_valid, 1'b0);
    chk("t6_busy_after_rst", busy_le, 1'b0);
    repeat (5) tick();
    chk("t6_no_done", done_cnt, 0);
    clear_caps();
    pulse_start();
    wait_done("t6");
    check_frame("t6");

    // 7: start accepted in the done cycle, distinct data in several registers
    regs[0]  = 32'hA1B2C3D4;
    regs[15] = 32'h0F0E0D0C;
    clear_caps();
    pulse_start();
    for (int i = 0; i < 200 && !(active && q0.size() == 1); i++) tick();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && done_cnt < 2; i++) tick();
    chk("t7_two_frames", done_cnt, 2);
    chk("t7_second_frame_len", cap0.size(), 132);
    if (cap0.size() > 67) chk("t7_second_hdr", cap0[66], 9'h0A5);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
